// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
//   Owns the single register-file write port and shares it between the
//   in-order pipeline writeback and a long-latency result source (mul/div,
//   late loads). Late results wait in a small FIFO. The pipeline wins the
//   port unless the FIFO is full or has starved for STARVE_LIMIT cycles, or
//   the pipeline is idle. Decode gets a pending-write hazard check.
//
// Ports
//   clk, rst                   rising-edge clock, async active-high reset
//   pipe_valid/rd/data         pipeline writeback request
//   pipe_stall                 request not taken this cycle; hold and retry
//   late_valid/rd/data         late result offer
//   late_ready                 FIFO has room (registered state only)
//   rs1_addr, rs2_addr         decode source registers
//   rs1_busy, rs2_busy         source has a pending late / in-flight write
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
module riscv_wb_arbiter #(
  parameter int WORD_LENGTH  = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_valid,
  input  logic [REG_ADDR_W-1:0]  pipe_rd,
  input  logic [WORD_LENGTH-1:0] pipe_data,
  output logic                   pipe_stall,
  input  logic                   late_valid,
  input  logic [REG_ADDR_W-1:0]  late_rd,
  input  logic [WORD_LENGTH-1:0] late_data,
  output logic                   late_ready,
  input  logic [REG_ADDR_W-1:0]  rs1_addr,
  input  logic [REG_ADDR_W-1:0]  rs2_addr,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rf_we,
  output logic [REG_ADDR_W-1:0]  rf_waddr,
  output logic [WORD_LENGTH-1:0] rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  // FIFO storage; per-entry valid bits feed the hazard check directly.
  logic [REG_ADDR_W-1:0]  fifo_rd   [DEPTH];
  logic [WORD_LENGTH-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]       fifo_vld;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [ST_W-1:0]        starve_cnt;

  logic                   full;
  logic                   empty;
  logic                   starve_hit;
  logic                   push;
  logic                   drain;
  logic                   sel_valid;
  logic [REG_ADDR_W-1:0]  sel_rd;
  logic [WORD_LENGTH-1:0] sel_data;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign starve_hit = (starve_cnt >= ST_W'(STARVE_LIMIT));

  // Ready depends only on registered occupancy; held low during reset.
  assign late_ready = !full && !rst;
  assign push       = late_valid && late_ready;

  // Grant: FIFO head wins when the pipe is idle, the FIFO is full or starved.
  always_comb begin
    drain     = !empty && (!pipe_valid || full || starve_hit);
    sel_valid = drain || pipe_valid;
    sel_rd    = pipe_rd;
    sel_data  = pipe_data;
    if (drain) begin
      sel_rd   = fifo_rd[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end
  end

  assign pipe_stall = pipe_valid && drain;

  // FIFO storage is not reset; validity is tracked by fifo_vld.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= late_rd;
      fifo_data[wr_ptr] <= late_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        fifo_vld[wr_ptr] <= 1'b1;
      end
      // Push and pop never target the same slot unless the FIFO is empty,
      // in which case drain is 0, so the clear cannot race the set.
      if (drain) begin
        rd_ptr           <= rd_ptr + PTR_W'(1);
        fifo_vld[rd_ptr] <= 1'b0;
      end
      case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Starve counter: counts cycles the head sat un-popped, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (drain || empty) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  // Write port register; rd=0 requests are consumed without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Hazard check against queued late writes and the write in flight.
  always_comb begin
    rs1_busy = rf_we && (rf_waddr == rs1_addr);
    rs2_busy = rf_we && (rf_waddr == rs2_addr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == rs1_addr)) rs1_busy = 1'b1;
      if (fifo_vld[i] && (fifo_rd[i] == rs2_addr)) rs2_busy = 1'b1;
    end
    if (rs1_addr == '0) rs1_busy = 1'b0;
    if (rs2_addr == '0) rs2_busy = 1'b0;
  end

endmodule
